lhn_prod_acc: RTL and testbench
===============================

# lhn_prod_acc

Downstream consumer of the sequential multiplier's 11-bit product stream. It accepts products over a valid/ready handshake and sums a frame of N_SAMPLES products with a saturating accumulator. It then presents the frame sum, the frame average and a saturation flag to the next ALU stage over a second valid/ready handshake. It turns the multiplier's per-cycle result into frame-level statistics for the pipeline ALU.

## Interface
- PROD_W, 11: product width, matches the multiplier's final_product.
- ACC_W, 13: accumulator width; must be at least PROD_W.
- N_SAMPLES, 8: products per frame; a power of two, from 2 to 64.
- LOG2_N, 3: log2(N_SAMPLES); sets the average shift.

Ports:
- clock  in  1  Single rising-edge clock.
- reset_n  in  1  Asynchronous, active-low reset.
- prod_in  in  PROD_W  Product from the multiplier.
- prod_valid  in  1  prod_in is valid this cycle.
- prod_ready  out  1  Block accepts a product this cycle.
- clear  in  1  Synchronous frame abort; highest priority.
- acc_out  out  ACC_W  Frame sum, saturated.
- avg_out  out  ACC_W  acc_out >> LOG2_N.
- sat_flag  out  1  Some addition in this frame clamped.
- acc_valid  out  1  Frame result is available.
- acc_ready  in  1  Downstream takes the frame result.
- count  out  7  Products accepted in the current frame.

## Operation
- State machine with two states:
  - ACCUM: accept products.
  - HOLD: present the result.
- prod_ready = (state==ACCUM) & ~clear. This is combinational, with no dependence on prod_valid.
- Accept condition is prod_valid & prod_ready. On accept:
  - acc <= sat_add(acc, zero-extended prod_in).
  - count increments.
  - sat_flag <= sat_flag | overflow.
- Saturating add: form the sum at ACC_W+1 bits. If bit ACC_W is set, the result is 2^ACC_W-1 and overflow=1. Once saturated, acc stays at the maximum for the rest of the frame.
- Frame completion:
  - An accept that makes count reach N_SAMPLES moves the state to HOLD.
  - count holds at N_SAMPLES.
- HOLD:
  - acc_valid=1. acc_out, avg_out and sat_flag stay stable and prod_ready=0.
  - When acc_valid & acc_ready: acc, count and sat_flag clear to 0 and the state returns to ACCUM.
- clear (either state): acc, count and sat_flag go to 0 and the state goes to ACCUM. Any same-cycle product or acc_ready handshake is ignored.
- acc_out and avg_out are registered outputs and show the running value during ACCUM. Consumers sample them only when acc_valid=1.

## Timing
- Reset values: state ACCUM; acc_out, avg_out, sat_flag, acc_valid and count all 0. prod_ready is 1 once reset_n is high and clear=0.
- Reset asserted mid-frame or mid-HOLD: the result is discarded immediately, asynchronously.
- Accept-to-acc_out latency is 1 cycle.
- The Nth accept at edge k raises acc_valid after edge k, so it is visible in cycle k+1.
- Throughput is one product per cycle in ACCUM, with no bubbles between accepts.
- HOLD→ACCUM takes 1 cycle. The first product of the next frame can be accepted in the cycle after the acc_ready handshake.
- Minimum frame period is N_SAMPLES+1 cycles.
- prod_valid=0 gaps stall the frame with acc and count unchanged.
- A zero product still counts as a sample.
- If acc_ready is held high in ACCUM, it has no effect.

## Structure
- Package lhn_acc_pkg holds:
  - State encoding: ACCUM=1'b0, HOLD=1'b1.
  - Default width and count constants: PROD_W, ACC_W, N_SAMPLES, LOG2_N.
- Sub-module lhn_sat_add is a combinational saturating adder:
  - Inputs: a, of width ACC_W, and b, of width PROD_W.
  - Outputs: sum, of width ACC_W, and ovf.
- Top level contains the FSM, the counter and the output registers, in about 150–250 lines.

## Test plan
- Reset then stream 100, 200, 300, 400, 50, 60, 70, 80 with acc_ready=1:
  - acc_valid pulses once, with acc_out=1260, avg_out=157, sat_flag=0.
  - The first product of the next frame is accepted in the following cycle.
- Eight products of 2047 (ACC_W=13):
  - Saturation occurs on the 5th accept.
  - Final acc_out=8191, avg_out=1023, sat_flag=1.
  - The next frame starts with sat_flag=0.
- Backpressure: hold acc_ready=0 for 5 cycles after a frame completes.
  - acc_valid and acc_out stay stable and prod_ready=0.
  - A product presented during this time is not consumed.
  - It is accepted after acc_ready rises.
- clear asserted after 3 accepts, in the same cycle as prod_valid=1:
  - count=0 and acc_out=0 next cycle, and that product is dropped.
  - A full 8-product frame of 10 then yields acc_out=80.
- Gapped input: alternate prod_valid 1/0 with 25 each valid cycle.
  - acc_valid asserts only after the 8th accept, with acc_out=200.
- reset_n pulsed low while in HOLD:
  - All outputs are 0 immediately.
  - prod_ready=1 after release.

Source files
------------

// File: rtl/lhn_acc_pkg.sv
// rtl/lhn_acc_pkg.sv - shared state encoding and default sizing for the product accumulator
package lhn_acc_pkg;

    localparam int PROD_W    = 11;
    localparam int ACC_W     = 13;
    localparam int N_SAMPLES = 8;
    localparam int LOG2_N    = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/lhn_sat_add.sv
// rtl/lhn_sat_add.sv - combinational saturating adder of an unsigned product into the accumulator
module lhn_sat_add #(
    parameter int ACC_W  = 13,
    parameter int PROD_W = 11
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    // One guard bit is enough: b never exceeds a's range since ACC_W >= PROD_W.
    assign full = {1'b0, a} + (ACC_W+1)'(b);
    assign ovf  = full[ACC_W];
    assign sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

// File: rtl/lhn_prod_acc.sv
// rtl/lhn_prod_acc.sv - frames N_SAMPLES multiplier products into a saturated sum, average and flag
module lhn_prod_acc #(
    parameter int PROD_W    = 11,
    parameter int ACC_W     = 13,
    parameter int N_SAMPLES = 8,
    parameter int LOG2_N    = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  acc_out,
    output logic [ACC_W-1:0]  avg_out,
    output logic              sat_flag,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [6:0]        count
);

    import lhn_acc_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [6:0]       cnt;
    logic             sat;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             frame_done;
    logic             drained;

    lhn_sat_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_add (
        .a   (acc),
        .b   (prod_in),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign accept     = prod_valid & prod_ready;
    assign frame_done = accept && (cnt == 7'(N_SAMPLES - 1));
    assign drained    = acc_valid & acc_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (frame_done) state_nxt = HOLD;
                HOLD:    if (drained)    state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    always_comb begin
        prod_ready = (state == ACCUM) & ~clear;
        acc_valid  = (state == HOLD);
    end

    // clear outranks both handshakes; acc_ready only matters while a result is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (clear || drained) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            acc <= add_sum;
            cnt <= cnt + 7'd1;
            sat <= sat | add_ovf;
        end
    end

    assign acc_out  = acc;
    assign avg_out  = acc >> LOG2_N;
    assign sat_flag = sat;
    assign count    = cnt;

endmodule

// File: tb/tb_lhn_prod_acc.sv
// tb/tb_lhn_prod_acc.sv - self-checking bench: queue-based frame model plus directed and random stimulus
module tb_lhn_prod_acc;

    localparam int N      = 8;
    localparam int ACCMAX = 8191;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] prod_in = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic        clear = 1'b0;
    logic [12:0] acc_out;
    logic [12:0] avg_out;
    logic        sat_flag;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic [6:0]  count;

    int total = 0;
    int bad   = 0;
    int q[$];

    lhn_prod_acc dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear      (clear),
        .acc_out    (acc_out),
        .avg_out    (avg_out),
        .sat_flag   (sat_flag),
        .acc_valid  (acc_valid),
        .acc_ready  (acc_ready),
        .count      (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the current frame is just the list of products accepted so far.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
        end else if (clear) begin
            q.delete();
        end else if (q.size() == N) begin
            if (acc_ready) q.delete();
        end else if (prod_valid) begin
            q.push_back(int'(prod_in));
        end
    end

    function automatic void fold(output int acc, output int sat);
        acc = 0;
        sat = 0;
        foreach (q[i]) begin
            acc = acc + q[i];
            if (acc > ACCMAX) begin
                acc = ACCMAX;
                sat = 1;
            end
        end
    endfunction

    always @(negedge clock) begin
        int e_acc;
        int e_sat;
        if (reset_n) begin
            fold(e_acc, e_sat);
            chk("m_prod_ready", int'(prod_ready), int'(q.size() < N && !clear));
            chk("m_acc_valid", int'(acc_valid), int'(q.size() == N));
            chk("m_count", int'(count), q.size());
            chk("m_acc_out", int'(acc_out), e_acc);
            chk("m_avg_out", int'(avg_out), e_acc / N);
            chk("m_sat_flag", int'(sat_flag), e_sat);
        end
    end

    task automatic step(input logic v, input int p, input logic r, input logic c);
        prod_valid = v;
        prod_in    = 11'(p);
        acc_ready  = r;
        clear      = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int vals1[8] = '{100, 200, 300, 400, 50, 60, 70, 80};
        int held;

        #1;
        chk("rst_acc_valid", int'(acc_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_sat", int'(sat_flag), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_prod_ready", int'(prod_ready), 1);
        @(posedge clock);
        #1;

        // Frame 1 with acc_ready high throughout
        for (int i = 0; i < 8; i++) step(1'b1, vals1[i], 1'b1, 1'b0);
        chk("f1_valid", int'(acc_valid), 1);
        chk("f1_acc", int'(acc_out), 1260);
        chk("f1_avg", int'(avg_out), 157);
        chk("f1_sat", int'(sat_flag), 0);
        step(1'b1, 7, 1'b1, 1'b0);
        chk("f1_pulse_once", int'(acc_valid), 0);
        chk("f1_next_cnt0", int'(count), 0);
        step(1'b1, 7, 1'b1, 1'b0);
        chk("f2_first_accept", int'(count), 1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Saturation frame
        for (int i = 0; i < 4; i++) step(1'b1, 2047, 1'b1, 1'b0);
        chk("sat4_acc", int'(acc_out), 8188);
        chk("sat4_flag", int'(sat_flag), 0);
        step(1'b1, 2047, 1'b1, 1'b0);
        chk("sat5_acc", int'(acc_out), 8191);
        chk("sat5_flag", int'(sat_flag), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 2047, 1'b0, 1'b0);
        chk("sat_acc", int'(acc_out), 8191);
        chk("sat_avg", int'(avg_out), 1023);
        chk("sat_flag_final", int'(sat_flag), 1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("sat_next_flag", int'(sat_flag), 0);

        // Backpressure
        for (int i = 0; i < 8; i++) step(1'b1, $urandom_range(0, 1000), 1'b0, 1'b0);
        held = int'(acc_out);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 99, 1'b0, 1'b0);
            chk("bp_valid", int'(acc_valid), 1);
            chk("bp_ready", int'(prod_ready), 0);
            chk("bp_acc", int'(acc_out), held);
        end
        step(1'b1, 99, 1'b1, 1'b0);
        step(1'b1, 99, 1'b0, 1'b0);
        chk("bp_taken_cnt", int'(count), 1);
        chk("bp_taken_acc", int'(acc_out), 99);

        // clear after 3 accepts, colliding with a product
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 10, 1'b0, 1'b0);
        step(1'b1, 10, 1'b0, 1'b1);
        chk("clr_cnt", int'(count), 0);
        chk("clr_acc", int'(acc_out), 0);
        for (int i = 0; i < 8; i++) step(1'b1, 10, 1'b0, 1'b0);
        chk("clr_frame_acc", int'(acc_out), 80);
        chk("clr_frame_valid", int'(acc_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0);

        // Gapped input
        for (int i = 0; i < 16; i++) begin
            step(1'(i % 2 == 0), 25, 1'b0, 1'b0);
            if (i < 14) chk("gap_no_valid", int'(acc_valid), 0);
        end
        chk("gap_valid", int'(acc_valid), 1);
        chk("gap_acc", int'(acc_out), 200);
        step(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0) ? 2047 : $urandom_range(0, 2047),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0));
        end

        // Reset while holding a result
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 500, 1'b0, 1'b0);
        chk("hold_before_rst", int'(acc_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", int'(acc_valid), 0);
        chk("arst_acc", int'(acc_out), 0);
        chk("arst_avg", int'(avg_out), 0);
        chk("arst_sat", int'(sat_flag), 0);
        chk("arst_cnt", int'(count), 0);
        @(posedge clock);
        #1;
        prod_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("arst_ready_after", int'(prod_ready), 1);
        step(1'b1, 3, 1'b0, 1'b0);
        chk("arst_first_acc", int'(acc_out), 3);
        step(1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
